// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
// Initiator side of the 512x8 big-endian data RAM. Takes one load/store
// request at a time from the pipeline, traps misaligned requests, splits a
// doubleword into two word accesses (high word first) and returns one
// single-cycle response per request.
module mem_access_sequencer #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_rw,
    input  logic [1:0]            req_size,
    input  logic                  req_se,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    output logic                  resp_valid,
    output logic [2*DATA_W-1:0]   resp_rdata,
    output logic                  resp_trap,
    output logic                  ram_rw,
    output logic [ADDR_W-1:0]     ram_address,
    output logic [DATA_W-1:0]     ram_datain,
    output logic [1:0]            ram_size,
    output logic                  ram_se,
    output logic                  ram_e,
    input  logic [DATA_W-1:0]     ram_dataout
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    localparam logic [1:0] SIZE_BYTE   = 2'b00;
    localparam logic [1:0] SIZE_HALF   = 2'b01;
    localparam logic [1:0] SIZE_WORD   = 2'b10;
    localparam logic [1:0] SIZE_DOUBLE = 2'b11;

    state_t              state;
    logic                acc_double;
    logic                acc_load;
    logic [DATA_W-1:0]   wdata_lo;
    logic                aligned;
    logic [DATA_W-1:0]   store_word;

    // Decide alignment of the incoming request and pick the first store word.
    // The high half of a double goes out first because the RAM is big-endian.
    always_comb begin
        aligned    = 1'b1;
        store_word = '0;
        case (req_size)
            SIZE_BYTE: begin
                aligned    = 1'b1;
                store_word = {{(DATA_W-8){1'b0}}, req_wdata[7:0]};
            end
            SIZE_HALF: begin
                aligned    = ~req_addr[0];
                store_word = {{(DATA_W-16){1'b0}}, req_wdata[15:0]};
            end
            SIZE_WORD: begin
                aligned    = (req_addr[1:0] == 2'b00);
                store_word = req_wdata[DATA_W-1:0];
            end
            default: begin
                aligned    = (req_addr[2:0] == 3'b000);
                store_word = req_wdata[2*DATA_W-1:DATA_W];
            end
        endcase
    end

    // Sequencer FSM; every output is a register so the RAM sees clean,
    // glitch-free controls and ram_rw is only ever high together with ram_e.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_trap   <= 1'b0;
            ram_rw      <= 1'b0;
            ram_address <= '0;
            ram_datain  <= '0;
            ram_size    <= 2'b00;
            ram_se      <= 1'b0;
            ram_e       <= 1'b0;
            acc_double  <= 1'b0;
            acc_load    <= 1'b0;
            wdata_lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    resp_valid <= 1'b0;
                    if (req_valid && req_ready) begin
                        req_ready  <= 1'b0;
                        resp_rdata <= '0;
                        resp_trap  <= 1'b0;
                        acc_double <= (req_size == SIZE_DOUBLE);
                        acc_load   <= ~req_rw;
                        wdata_lo   <= req_wdata[DATA_W-1:0];
                        if (!aligned) begin
                            state      <= RESP;
                            resp_trap  <= 1'b1;
                            resp_valid <= 1'b1;
                        end else begin
                            state       <= ACC0;
                            ram_e       <= 1'b1;
                            ram_rw      <= req_rw;
                            ram_address <= req_addr;
                            ram_size    <= (req_size == SIZE_DOUBLE) ? SIZE_WORD : req_size;
                            ram_se      <= (!req_rw && !req_size[1]) ? req_se : 1'b0;
                            ram_datain  <= req_rw ? store_word : '0;
                        end
                    end
                end
                ACC0: begin
                    if (acc_load) begin
                        if (acc_double)
                            resp_rdata[2*DATA_W-1:DATA_W] <= ram_dataout;
                        else
                            resp_rdata[DATA_W-1:0] <= ram_dataout;
                    end
                    if (acc_double) begin
                        state       <= ACC1;
                        ram_address <= ram_address + ADDR_W'(4);
                        if (!acc_load)
                            ram_datain <= wdata_lo;
                    end else begin
                        state      <= RESP;
                        ram_e      <= 1'b0;
                        ram_rw     <= 1'b0;
                        resp_valid <= 1'b1;
                    end
                end
                ACC1: begin
                    if (acc_load)
                        resp_rdata[DATA_W-1:0] <= ram_dataout;
                    state      <= RESP;
                    ram_e      <= 1'b0;
                    ram_rw     <= 1'b0;
                    resp_valid <= 1'b1;
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Testbench for mem_access_sequencer: a behavioural big-endian 512x8 RAM,
// a byte-array reference model of memory contents, and directed plus
// randomized request scenarios.
module tb_mem_access_sequencer;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_rw;
    logic [1:0]  req_size;
    logic        req_se;
    logic [8:0]  req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_trap;
    logic        ram_rw;
    logic [8:0]  ram_address;
    logic [31:0] ram_datain;
    logic [1:0]  ram_size;
    logic        ram_se;
    logic        ram_e;
    logic [31:0] ram_dataout;

    int tests_run;
    int tests_failed;

    logic [7:0] mem     [512];
    logic [7:0] ref_mem [512];

    // observations of the most recent request
    int          obs_lat;
    int          obs_ecount;
    logic        obs_trap;
    logic [63:0] obs_rdata;
    logic [8:0]  obs_addr [2];
    logic [31:0] obs_data [2];
    logic [1:0]  obs_size0;
    logic        obs_ready_drive;
    logic        obs_ready_busy;
    logic        obs_rw_bad;
    logic        obs_after_valid;
    logic        obs_after_ready;
    logic [63:0] obs_after_rdata;
    logic        obs_after_trap;

    // reference expectations of the most recent request
    logic        exp_trap;
    logic [63:0] exp_rdata;
    int          exp_lat;
    int          exp_ecount;

    mem_access_sequencer #(.ADDR_W(9), .DATA_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rw      (req_rw),
        .req_size    (req_size),
        .req_se      (req_se),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_trap   (resp_trap),
        .ram_rw      (ram_rw),
        .ram_address (ram_address),
        .ram_datain  (ram_datain),
        .ram_size    (ram_size),
        .ram_se      (ram_se),
        .ram_e       (ram_e),
        .ram_dataout (ram_dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM write port: big-endian, committed on the clock edge
    always @(posedge clk) begin
        if (ram_e && ram_rw) begin
            case (ram_size)
                2'b00: mem[ram_address] <= ram_datain[7:0];
                2'b01: begin
                    mem[ram_address]        <= ram_datain[15:8];
                    mem[ram_address + 9'd1] <= ram_datain[7:0];
                end
                default: begin
                    mem[ram_address]        <= ram_datain[31:24];
                    mem[ram_address + 9'd1] <= ram_datain[23:16];
                    mem[ram_address + 9'd2] <= ram_datain[15:8];
                    mem[ram_address + 9'd3] <= ram_datain[7:0];
                end
            endcase
        end
    end

    // RAM read port: combinational, with optional sign extension
    always_comb begin
        ram_dataout = 32'h0;
        if (ram_e && !ram_rw) begin
            case (ram_size)
                2'b00: ram_dataout = {{24{ram_se & mem[ram_address][7]}}, mem[ram_address]};
                2'b01: ram_dataout = {{16{ram_se & mem[ram_address][7]}}, mem[ram_address],
                                      mem[ram_address + 9'd1]};
                default: ram_dataout = {mem[ram_address], mem[ram_address + 9'd1],
                                        mem[ram_address + 9'd2], mem[ram_address + 9'd3]};
            endcase
        end
    end

    function automatic logic [31:0] ref_word(input int a);
        return {ref_mem[a % 512], ref_mem[(a + 1) % 512], ref_mem[(a + 2) % 512], ref_mem[(a + 3) % 512]};
    endfunction

    // Reference model: computes the expected response and updates ref_mem
    task automatic model_access(input logic rw, input logic [1:0] size, input logic se,
                                input logic [8:0] addr, input logic [63:0] wdata);
        int a;
        int nbytes;
        logic [31:0] w;
        a      = int'(addr);
        nbytes = 1 << size;
        exp_rdata = 64'h0;
        if ((a % nbytes) != 0) begin
            exp_trap   = 1'b1;
            exp_lat    = 1;
            exp_ecount = 0;
        end else begin
            exp_trap   = 1'b0;
            exp_lat    = (nbytes == 8) ? 3 : 2;
            exp_ecount = (nbytes == 8) ? 2 : 1;
            if (rw) begin
                for (int i = 0; i < nbytes; i++)
                    ref_mem[a + i] = wdata[8*(nbytes-1-i) +: 8];
            end else begin
                w = ref_word(a);
                case (nbytes)
                    1: begin
                        exp_rdata[7:0] = ref_mem[a];
                        if (se && ref_mem[a][7]) exp_rdata[31:8] = 24'hFFFFFF;
                    end
                    2: begin
                        exp_rdata[15:0] = {ref_mem[a], ref_mem[a + 1]};
                        if (se && ref_mem[a][7]) exp_rdata[31:16] = 16'hFFFF;
                    end
                    4: exp_rdata[31:0] = w;
                    default: exp_rdata = {w, ref_word(a + 4)};
                endcase
            end
        end
    endtask

    // Drive one request at a negedge and watch it until its response, then
    // one further cycle; leaves the bench at a negedge with the DUT idle.
    task automatic applyStimulus(input logic rw, input logic [1:0] size, input logic se,
                                 input logic [8:0] addr, input logic [63:0] wdata);
        model_access(rw, size, se, addr, wdata);
        obs_ready_drive = req_ready;
        req_valid = 1'b1;
        req_rw    = rw;
        req_size  = size;
        req_se    = se;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid      = 1'b0;
        obs_lat        = 0;
        obs_ecount     = 0;
        obs_trap       = 1'b0;
        obs_rdata      = 64'h0;
        obs_ready_busy = 1'b0;
        obs_rw_bad     = 1'b0;
        obs_size0      = 2'b11;
        obs_addr[0] = 9'h0;  obs_addr[1] = 9'h0;
        obs_data[0] = 32'h0; obs_data[1] = 32'h0;
        for (int n = 1; n <= 8 && obs_lat == 0; n++) begin
            @(negedge clk);
            if (ram_rw && !ram_e) obs_rw_bad = 1'b1;
            if (ram_e) begin
                if (obs_ecount < 2) begin
                    obs_addr[obs_ecount] = ram_address;
                    obs_data[obs_ecount] = ram_datain;
                    if (obs_ecount == 0) obs_size0 = ram_size;
                end
                obs_ecount++;
            end
            if (resp_valid) begin
                obs_lat   = n;
                obs_trap  = resp_trap;
                obs_rdata = resp_rdata;
            end else if (req_ready) begin
                obs_ready_busy = 1'b1;
            end
        end
        @(negedge clk);
        obs_after_valid = resp_valid;
        obs_after_ready = req_ready;
        obs_after_rdata = resp_rdata;
        obs_after_trap  = resp_trap;
        if (ram_rw && !ram_e) obs_rw_bad = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_ready: got %b expected 1", req_ready);
        end
        tests_run++;
        if ({resp_valid, resp_trap, resp_rdata} !== 66'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_resp: got valid=%b trap=%b rdata=%h expected all zero",
                     resp_valid, resp_trap, resp_rdata);
        end
        tests_run++;
        if ({ram_rw, ram_address, ram_datain, ram_size, ram_se, ram_e} !== 46'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ram: got rw=%b addr=%h din=%h size=%b se=%b e=%b expected all zero",
                     ram_rw, ram_address, ram_datain, ram_size, ram_se, ram_e);
        end
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({req_ready, resp_valid, ram_e} !== 3'b100) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_idle: got ready/valid/e=%b expected 100",
                     {req_ready, resp_valid, ram_e});
        end
    endtask

    task automatic test_word_load;
        applyStimulus(1'b0, 2'b10, 1'b0, 9'd0, 64'h0);
        tests_run++;
        if (obs_rdata !== 64'h0000_0000_0123_4567 || obs_trap !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL word_load_data: got %h trap=%b expected 0000000001234567 trap=0",
                     obs_rdata, obs_trap);
        end
        tests_run++;
        if (obs_lat !== 2) begin
            tests_failed++;
            $display("[TB] FAIL word_load_latency: got %0d expected 2", obs_lat);
        end
        tests_run++;
        if ({obs_ready_drive, obs_ready_busy, obs_after_ready, obs_after_valid} !== 4'b1010) begin
            tests_failed++;
            $display("[TB] FAIL word_load_handshake: got drive/busy/after_ready/after_valid=%b expected 1010",
                     {obs_ready_drive, obs_ready_busy, obs_after_ready, obs_after_valid});
        end
        tests_run++;
        if (obs_after_rdata !== 64'h0000_0000_0123_4567) begin
            tests_failed++;
            $display("[TB] FAIL rdata_retention: got %h expected 0000000001234567", obs_after_rdata);
        end
    endtask

    task automatic test_byte_loads;
        applyStimulus(1'b0, 2'b00, 1'b1, 9'd4, 64'h0);
        tests_run++;
        if (obs_rdata !== 64'h0000_0000_FFFF_FF89 || obs_size0 !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL byte_load_se: got %h size=%b expected 00000000FFFFFF89 size=00",
                     obs_rdata, obs_size0);
        end
        applyStimulus(1'b0, 2'b00, 1'b0, 9'd4, 64'h0);
        tests_run++;
        if (obs_rdata !== 64'h0000_0000_0000_0089 || obs_size0 !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL byte_load_zx: got %h size=%b expected 0000000000000089 size=00",
                     obs_rdata, obs_size0);
        end
    endtask

    task automatic test_half_store_load;
        applyStimulus(1'b1, 2'b01, 1'b0, 9'd2, 64'h1234_5678_9ABC_A5AD);
        tests_run++;
        if (obs_rdata !== 64'h0 || obs_lat !== 2 || obs_data[0] !== 32'h0000_A5AD) begin
            tests_failed++;
            $display("[TB] FAIL half_store: got rdata=%h lat=%0d din=%h expected 0 lat=2 din=0000a5ad",
                     obs_rdata, obs_lat, obs_data[0]);
        end
        applyStimulus(1'b0, 2'b01, 1'b1, 9'd2, 64'h0);
        tests_run++;
        if (obs_rdata !== 64'h0000_0000_FFFF_A5AD) begin
            tests_failed++;
            $display("[TB] FAIL half_load_se: got %h expected 00000000FFFFA5AD", obs_rdata);
        end
        applyStimulus(1'b0, 2'b10, 1'b0, 9'd0, 64'h0);
        tests_run++;
        if (obs_rdata !== 64'h0000_0000_0123_A5AD) begin
            tests_failed++;
            $display("[TB] FAIL word_after_half: got %h expected 000000000123A5AD", obs_rdata);
        end
    endtask

    task automatic test_double;
        applyStimulus(1'b1, 2'b11, 1'b0, 9'd8, 64'h8567C6AB_DEADBEEF);
        tests_run++;
        if (obs_ecount !== 2 || obs_addr[0] !== 9'd8 || obs_addr[1] !== 9'd12) begin
            tests_failed++;
            $display("[TB] FAIL double_store_addr: got count=%0d addrs=%0d,%0d expected 2 and 8,12",
                     obs_ecount, obs_addr[0], obs_addr[1]);
        end
        tests_run++;
        if (obs_data[0] !== 32'h8567C6AB || obs_data[1] !== 32'hDEADBEEF || obs_size0 !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL double_store_data: got %h,%h size=%b expected 8567c6ab,deadbeef size=10",
                     obs_data[0], obs_data[1], obs_size0);
        end
        applyStimulus(1'b0, 2'b11, 1'b0, 9'd8, 64'h0);
        tests_run++;
        if (obs_rdata !== 64'h8567C6AB_DEADBEEF || obs_lat !== 3) begin
            tests_failed++;
            $display("[TB] FAIL double_load: got %h lat=%0d expected 8567c6abdeadbeef lat=3",
                     obs_rdata, obs_lat);
        end
    endtask

    task automatic test_misaligned;
        logic [63:0] low_bytes;
        applyStimulus(1'b0, 2'b10, 1'b0, 9'd6, 64'h0);
        tests_run++;
        if (obs_trap !== 1'b1 || obs_lat !== 1 || obs_ecount !== 0 || obs_rdata !== 64'h0) begin
            tests_failed++;
            $display("[TB] FAIL misaligned_word: got trap=%b lat=%0d ecount=%0d rdata=%h expected 1 1 0 0",
                     obs_trap, obs_lat, obs_ecount, obs_rdata);
        end
        tests_run++;
        if (obs_after_trap !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL trap_retention: got %b expected 1", obs_after_trap);
        end
        applyStimulus(1'b1, 2'b01, 1'b0, 9'd3, 64'hFFFF_FFFF_FFFF_FFFF);
        tests_run++;
        if (obs_trap !== 1'b1 || obs_lat !== 1 || obs_ecount !== 0) begin
            tests_failed++;
            $display("[TB] FAIL misaligned_half_store: got trap=%b lat=%0d ecount=%0d expected 1 1 0",
                     obs_trap, obs_lat, obs_ecount);
        end
        low_bytes = {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5], mem[6], mem[7]};
        tests_run++;
        if (low_bytes !== 64'h0123A5AD_89ABCDEF) begin
            tests_failed++;
            $display("[TB] FAIL misaligned_memory: got %h expected 0123a5ad89abcdef", low_bytes);
        end
    endtask

    task automatic test_back_to_back;
        applyStimulus(1'b1, 2'b10, 1'b0, 9'd32, 64'h0000_0000_CAFE_F00D);
        applyStimulus(1'b0, 2'b10, 1'b0, 9'd32, 64'h0);
        tests_run++;
        if (obs_ready_drive !== 1'b1 || obs_lat !== 2 || obs_rdata !== 64'h0000_0000_CAFE_F00D) begin
            tests_failed++;
            $display("[TB] FAIL back_to_back: got ready=%b lat=%0d rdata=%h expected 1 2 00000000cafef00d",
                     obs_ready_drive, obs_lat, obs_rdata);
        end
    endtask

    task automatic test_reset_mid_double;
        int seen;
        req_valid = 1'b1;
        req_rw    = 1'b1;
        req_size  = 2'b11;
        req_se    = 1'b0;
        req_addr  = 9'd16;
        req_wdata = 64'h11223344_55667788;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (ram_e !== 1'b1 || ram_address !== 9'd20) begin
            tests_failed++;
            $display("[TB] FAIL mid_double_second_access: got e=%b addr=%0d expected 1 20", ram_e, ram_address);
        end
        #1;
        reset = 1'b1;
        #1;
        tests_run++;
        if ({ram_e, ram_rw, resp_valid, req_ready} !== 4'b0001) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: got e/rw/valid/ready=%b expected 0001",
                     {ram_e, ram_rw, resp_valid, req_ready});
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid || ram_e) seen++;
        end
        tests_run++;
        if (seen !== 0 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL after_reset_quiet: got activity=%0d ready=%b expected 0 1", seen, req_ready);
        end
        tests_run++;
        if ({mem[16], mem[17], mem[18], mem[19]} !== 32'h11223344 ||
            {mem[20], mem[21], mem[22], mem[23]} !== ref_word(20)) begin
            tests_failed++;
            $display("[TB] FAIL mid_double_memory: got %h %h expected 11223344 %h",
                     {mem[16], mem[17], mem[18], mem[19]}, {mem[20], mem[21], mem[22], mem[23]}, ref_word(20));
        end
        ref_mem[16] = 8'h11; ref_mem[17] = 8'h22; ref_mem[18] = 8'h33; ref_mem[19] = 8'h44;
    endtask

    task automatic test_random;
        int a;
        int sz;
        int diffs;
        logic [63:0] wd;
        for (int k = 0; k < 60; k++) begin
            sz = int'($urandom_range(0, 3));
            a  = int'($urandom_range(0, 511));
            if ($urandom_range(0, 3) != 0) a = a - (a % (1 << sz));
            if (k == 0) begin sz = 3; a = 504; end
            wd = {$urandom, $urandom};
            applyStimulus(1'($urandom_range(0, 1)), 2'(sz), 1'($urandom_range(0, 1)), 9'(a), wd);
            tests_run++;
            if (obs_trap !== exp_trap || obs_rdata !== exp_rdata || obs_lat !== exp_lat ||
                obs_ecount !== exp_ecount || obs_rw_bad !== 1'b0 || obs_after_valid !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL random_%0d size=%0d addr=%0d: got trap=%b rdata=%h lat=%0d e=%0d rwbad=%b pulse2=%b expected trap=%b rdata=%h lat=%0d e=%0d rwbad=0 pulse2=0",
                         k, sz, a, obs_trap, obs_rdata, obs_lat, obs_ecount, obs_rw_bad, obs_after_valid,
                         exp_trap, exp_rdata, exp_lat, exp_ecount);
            end
            if (exp_ecount == 2) begin
                tests_run++;
                if (obs_addr[1] !== 9'(a + 4)) begin
                    tests_failed++;
                    $display("[TB] FAIL random_%0d second_addr: got %0d expected %0d", k, obs_addr[1], a + 4);
                end
            end
        end
        diffs = 0;
        for (int i = 0; i < 512; i++)
            if (mem[i] !== ref_mem[i]) diffs++;
        tests_run++;
        if (diffs != 0) begin
            tests_failed++;
            $display("[TB] FAIL memory_image: got %0d differing bytes expected 0", diffs);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_rw    = 1'b0;
        req_size  = 2'b00;
        req_se    = 1'b0;
        req_addr  = 9'd0;
        req_wdata = 64'h0;
        for (int i = 0; i < 512; i++) begin
            mem[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        for (int i = 0; i < 8; i++) begin
            mem[i]     = 8'(8'h01 + 8'h22 * i);
            ref_mem[i] = 8'(8'h01 + 8'h22 * i);
        end
        test_reset();
        test_word_load();
        test_byte_loads();
        test_half_store_load();
        test_double();
        test_misaligned();
        test_back_to_back();
        test_reset_mid_double();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
